// File: rtl/serial_byte_tx.sv
// ============================================================================
// Module      : serial_byte_tx
// Description : Framed parallel-to-serial transmitter (start, LSB-first data,
//               stop) with valid/ready intake and optional line inversion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_byte_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit INVERT_LINE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] inData,
    input  logic                 inValid,
    output logic                 outReady,
    output logic                 outTx,
    output logic                 outBusy
);

    localparam int c_CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic               c_IDLE_LVL = 1'b1 ^ INVERT_LINE;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [1:0]           r_state;
    logic [DATA_BITS-1:0] r_shreg;
    logic [c_CYC_W-1:0]   r_cycCnt;
    logic [c_BIT_W-1:0]   r_bitCnt;
    logic                 r_tx;
    logic                 r_busy;

    logic                 w_accept;
    logic                 w_cycDone;
    logic [DATA_BITS-1:0] w_shNext;

    assign outReady  = (r_state == c_ST_IDLE) && !rst;
    assign outTx     = r_tx;
    assign outBusy   = r_busy;

    assign w_accept  = inValid && outReady;
    assign w_cycDone = (r_cycCnt == c_CYC_LAST);
    assign w_shNext  = r_shreg >> 1;

    // Line level is loaded one bit ahead so outTx stays a pure register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_shreg  <= '0;
            r_cycCnt <= '0;
            r_bitCnt <= '0;
            r_tx     <= c_IDLE_LVL;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg  <= inData;
                        r_state  <= c_ST_START;
                        r_tx     <= ~c_IDLE_LVL;
                        r_busy   <= 1'b1;
                        r_cycCnt <= '0;
                        r_bitCnt <= '0;
                    end
                end
                c_ST_START: begin
                    if (w_cycDone) begin
                        r_cycCnt <= '0;
                        r_state  <= c_ST_DATA;
                        r_tx     <= r_shreg[0] ^ INVERT_LINE;
                    end else begin
                        r_cycCnt <= r_cycCnt + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (w_cycDone) begin
                        r_cycCnt <= '0;
                        if (r_bitCnt == c_BIT_LAST) begin
                            r_state <= c_ST_STOP;
                            r_tx    <= c_IDLE_LVL;
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                            r_shreg  <= w_shNext;
                            r_tx     <= w_shNext[0] ^ INVERT_LINE;
                        end
                    end else begin
                        r_cycCnt <= r_cycCnt + 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (w_cycDone) begin
                        r_cycCnt <= '0;
                        r_state  <= c_ST_IDLE;
                        r_busy   <= 1'b0;
                        r_tx     <= c_IDLE_LVL;
                    end else begin
                        r_cycCnt <= r_cycCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= c_IDLE_LVL;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
